rd_burst_arbiter: RTL and testbench
===================================

// Module: rd_burst_arbiter
// PURPOSE
//  Shares the read port of the async FIFO among NREQ consumers in the read clock domain.
//  Grants one consumer at a time a burst of up to MAXBURST pops, round-robin.
//  Drives the FIFO pop strobe (rinc) from the FIFO's registered empty flag.
//  Delivers each popped word to the owner, registered and tagged with the owner's ID.
//  Sits between the FIFO read-pointer/empty logic plus memory read port and the consumers.
// PARAMETERS
//  NREQ      4   number of consumers, >=2
//  DSIZE     8   FIFO data width
//  MAXBURST  4   max pops per grant, >=1; power of 2 not required
// PORTS
//  rclk      in   1            read-domain clock; all logic on posedge
//  rrst_n    in   1            asynchronous active-low reset
//  req       in   NREQ         per-consumer level request, doubles as ready-to-accept
//  rempty    in   1            FIFO empty flag (registered, rclk domain)
//  rdata     in   DSIZE        FIFO head word at current raddr (combinational read)
//  rinc      out  1            FIFO pop strobe
//  gnt       out  NREQ         one-hot owner, all-zero when idle
//  out_valid out  1            out_data/out_id valid this cycle
//  out_data  out  DSIZE        popped word
//  out_id    out  $clog2(NREQ) index of the consumer the word belongs to
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt=0, rinc=0, out_valid=0, out_data=0, out_id=0, rr_ptr=0, cnt=0.
//  A reset mid-burst drops the burst; no further rinc; the FIFO's own pointers are unaffected.
//  FSM IDLE:
//   - if !rempty && |req: winner = first set req at or above rr_ptr, wrapping.
//   - next cycle: BURST, owner=winner, gnt=onehot(winner), cnt=0.
//   - else remain IDLE.
//  FSM BURST:
//   - rinc = req[owner] & ~rempty; combinational, never asserted when rempty=1.
//   - each rinc: cnt++; the next cycle out_valid=1, out_data=rdata sampled at rinc, out_id=owner.
//   - exit to IDLE on any of these:
//     (a) rinc && cnt==MAXBURST-1 (last pop of burst);
//     (b) !req[owner];
//     (c) rempty (no pop that cycle).
//   - on exit: gnt=0 next cycle; rr_ptr = (owner+1) mod NREQ.
//  At least one IDLE cycle between bursts. Latency: req at cycle 0 -> gnt and first rinc at cycle 1 -> out_valid at cycle 2.
//  Simultaneous: rempty rising at the same edge as a pop ends the burst; pops already issued still produce out_valid.
//  Consumer dropping req mid-burst: no pop that cycle; burst ends.
//  Other requesters' req changes during a burst are ignored until IDLE.
//  cnt width $clog2(MAXBURST+1); it never wraps; it is cleared on each BURST entry.
//  rr_ptr wraps NREQ-1 -> 0.
//  Invariants: $onehot0(gnt); rinc -> |gnt; out_valid never at cycle following a non-pop.
// CONFIGURATION
//  RD_ARB_STATS_EN defined:
//   - adds output pop_cnt[15:0]: total rinc pulses since reset, wraps 0xFFFF -> 0;
//   - adds output burst_cnt[15:0]: BURST entries, same wrap;
//   - both reset to 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package rd_arb_pkg:
//   - typedef enum logic {IDLE, BURST} rd_arb_state_t;
//   - function onehot(idx) and localparam-style width helpers.
//  Sub-module rr_pick: combinational round-robin picker (req, rr_ptr -> winner, any).
//  Top holds the FSM, cnt, rr_ptr, output register and optional stats.
// TESTING
//  1. Reset: rrst_n=0 with req=4'b1111, rempty=0 -> gnt=0, rinc=0, out_valid=0 throughout.
//  2. Single consumer: req=4'b0100, FIFO holds 0xA1,0xA2:
//     - gnt=0100 at cycle 1; rinc at cycles 1-2;
//     - out_data 0xA1,0xA2 with out_id=2;
//     - rempty at cycle 3 -> IDLE.
//  3. Burst cap: MAXBURST=4, req=4'b0001, 10 words:
//     - exactly 4 rinc, then 1 IDLE cycle;
//     - re-grant to consumer 0; words in FIFO order.
//  4. Round-robin: req=4'b1111, FIFO full -> grant order 0,1,2,3,0, each burst of 4 pops.
//  5. Mid-burst req drop: consumer 1 drops req after 2 pops -> rinc stops the same cycle; next grant goes to 2.
//  6. Mid-burst reset: rrst_n low after 1 pop -> rinc=0 and gnt=0 immediately; no out_valid after release until a new grant.

Source files
------------

// File: rtl/rd_arb_pkg.sv
// Shared types and width helpers for the FIFO read-port burst arbiter.
package rd_arb_pkg;

    typedef enum logic {IDLE, BURST} rd_arb_state_t;

    localparam int MAX_NREQ = 32;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int maxburst);
        return $clog2(maxburst + 1);
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(input int idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping; zero latency, purely combinational.
module rr_pick
    import rd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    localparam logic [IDW:0] NREQ_EXT = (IDW+1)'(NREQ);

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;
    logic [IDW:0]    sum;

    always_comb begin
        // rot[i] is the request of consumer (rr_ptr + i) mod NREQ
        rot = NREQ'({req, req} >> rr_ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDW'(i);
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= NREQ_EXT) sum = sum - NREQ_EXT;
        winner = sum[IDW-1:0];
    end

    assign any = |req;

endmodule

// File: rtl/rd_burst_arbiter.sv
// Round-robin burst arbiter on the async FIFO read port; req->gnt/rinc 1 cycle, rinc->out_valid 1 cycle.
// Owner's req acts as ready (dropping it stops pops at once); RD_ARB_STATS_EN adds pop/burst counters.
module rd_burst_arbiter
    import rd_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    rempty,
    input  logic [DSIZE-1:0]        rdata,
    output logic                    rinc,
    output logic [NREQ-1:0]         gnt,
    output logic                    out_valid,
    output logic [DSIZE-1:0]        out_data,
    output logic [$clog2(NREQ)-1:0] out_id
`ifdef RD_ARB_STATS_EN
    ,
    output logic [15:0]             pop_cnt,
    output logic [15:0]             burst_cnt
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = cnt_w(MAXBURST);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAXBURST - 1);

    rd_arb_state_t  state, state_nxt;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] winner;
    logic           any;
    logic           burst_start;
    logic           burst_end;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        rinc        = 1'b0;
        burst_start = 1'b0;
        burst_end   = 1'b0;
        case (state)
            IDLE: begin
                if (!rempty && any) begin
                    burst_start = 1'b1;
                    state_nxt   = BURST;
                end
            end
            BURST: begin
                rinc = req[owner] & ~rempty;
                // a cycle without a pop (empty or owner not ready) also closes the burst
                if (!rinc || cnt == LAST_CNT) begin
                    burst_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt = (state == BURST) ? NREQ'(onehot(int'(owner))) : '0;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            owner  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            if (burst_start) begin
                owner <= winner;
                cnt   <= '0;
            end else if (rinc) begin
                cnt <= cnt + CW'(1);
            end
            if (burst_end) begin
                rr_ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            out_valid <= rinc;
            if (rinc) begin
                out_data <= rdata;
                out_id   <= owner;
            end
        end
    end

`ifdef RD_ARB_STATS_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pop_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            if (rinc)        pop_cnt   <= pop_cnt + 16'd1;
            if (burst_start) burst_cnt <= burst_cnt + 16'd1;
        end
    end
`else
    // statistics build option off: no counters
`endif

endmodule

// File: tb/tb_rd_burst_arbiter.sv
// Directed bench for rd_burst_arbiter with a simple registered-empty FIFO model on the read side.
module tb_rd_burst_arbiter;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [3:0] req;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic [3:0] gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
`ifdef RD_ARB_STATS_EN
    logic [15:0] pop_cnt;
    logic [15:0] burst_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;

    always #5 rclk = ~rclk;

    assign rempty = (wp == rp);
    assign rdata  = mem[rp];

    always @(posedge rclk) begin
        if (rinc) rp <= rp + 8'd1;
    end

    rd_burst_arbiter #(
        .NREQ     (4),
        .DSIZE    (8),
        .MAXBURST (4)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .req       (req),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef RD_ARB_STATS_EN
        ,
        .pop_cnt   (pop_cnt),
        .burst_cnt (burst_cnt)
`endif
    );

    task automatic push(input logic [7:0] d);
        mem[wp] = d;
        wp = wp + 8'd1;
    endtask

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
        end
    endtask

    task automatic now_chk(input string tag, input logic [3:0] eg, input logic er,
                           input logic eov, input logic [7:0] ed, input logic [1:0] eid);
        chk(tag, "gnt", 32'(gnt), 32'(eg));
        chk(tag, "rinc", 32'(rinc), 32'(er));
        chk(tag, "out_valid", 32'(out_valid), 32'(eov));
        if (eov) begin
            chk(tag, "out_data", 32'(out_data), 32'(ed));
            chk(tag, "out_id", 32'(out_id), 32'(eid));
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] eg, input logic er,
                       input logic eov, input logic [7:0] ed, input logic [1:0] eid);
        @(posedge rclk);
        #1;
        now_chk(tag, eg, er, eov, ed, eid);
    endtask

    initial begin
        // 1: reset held with all requests up and data waiting
        rrst_n = 1'b0;
        req    = 4'b1111;
        push(8'hA1);
        push(8'hA2);
        #1;
        now_chk("t1_rst", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        chk("t1_rst", "out_data", 32'(out_data), 32'h0);
        chk("t1_rst", "out_id", 32'(out_id), 32'h0);
        for (int i = 0; i < 3; i++) cyc("t1_hold", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        req    = 4'b0000;
        rrst_n = 1'b1;
        cyc("t1_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);

        // 2: single consumer 2, two words
        req = 4'b0100;
        #1;
        now_chk("t2_c0", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        cyc("t2_c1", 4'b0100, 1'b1, 1'b0, 8'h00, 2'd0);
        cyc("t2_c2", 4'b0100, 1'b1, 1'b1, 8'hA1, 2'd2);
        cyc("t2_c3", 4'b0100, 1'b0, 1'b1, 8'hA2, 2'd2);
        cyc("t2_c4", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        req = 4'b0000;

        // 3: burst cap with ten words for consumer 0
        req = 4'b0001;
        for (int i = 0; i < 10; i++) push(8'(8'hB0 + i));
        for (int k = 0; k < 2; k++) begin
            cyc("t3_grant", 4'b0001, 1'b1, 1'b0, 8'h00, 2'd0);
            for (int p = 0; p < 3; p++)
                cyc("t3_pop", 4'b0001, 1'b1, 1'b1, 8'(8'hB0 + 4*k + p), 2'd0);
            cyc("t3_gap", 4'b0000, 1'b0, 1'b1, 8'(8'hB0 + 4*k + 3), 2'd0);
        end
        cyc("t3_grant3", 4'b0001, 1'b1, 1'b0, 8'h00, 2'd0);
        cyc("t3_b8", 4'b0001, 1'b1, 1'b1, 8'hB8, 2'd0);
        cyc("t3_b9", 4'b0001, 1'b0, 1'b1, 8'hB9, 2'd0);
        cyc("t3_end", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        req = 4'b0000;

        // 4: all request, FIFO loaded; rr pointer starts from 0 after reset
        rrst_n = 1'b0;
        cyc("t4_rst", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        rrst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
        for (int b = 0; b < 5; b++) begin
            for (int p = 0; p < 4; p++)
                cyc("t4_burst", 4'(1 << (b % 4)), 1'b1, p > 0, 8'(8'h40 + 4*b + p - 1), 2'(b % 4));
            cyc("t4_gap", 4'b0000, 1'b0, 1'b1, 8'(8'h40 + 4*b + 3), 2'(b % 4));
        end
        req = 4'b0000;

        // 5: consumer 1 drops req after two pops; consumer 2 is next
        req = 4'b0110;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        cyc("t5_g1", 4'b0010, 1'b1, 1'b0, 8'h00, 2'd0);
        cyc("t5_p2", 4'b0010, 1'b1, 1'b1, 8'h60, 2'd1);
        @(posedge rclk);
        #1;
        req = 4'b0100;
        #1;
        now_chk("t5_drop", 4'b0010, 1'b0, 1'b1, 8'h61, 2'd1);
        cyc("t5_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        cyc("t5_g2", 4'b0100, 1'b1, 1'b0, 8'h00, 2'd0);
        cyc("t5_p62", 4'b0100, 1'b1, 1'b1, 8'h62, 2'd2);
        @(posedge rclk);
        #1;
        req = 4'b0000;
        #1;
        now_chk("t5_drop2", 4'b0100, 1'b0, 1'b1, 8'h63, 2'd2);
        cyc("t5_idle2", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);

        // 6: reset during a burst for consumer 3
        req = 4'b1000;
        cyc("t6_g", 4'b1000, 1'b1, 1'b0, 8'h00, 2'd0);
        @(posedge rclk);
        #1;
        rrst_n = 1'b0;
        #1;
        now_chk("t6_rst", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        chk("t6_rst", "out_data", 32'(out_data), 32'h0);
        cyc("t6_hold", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        rrst_n = 1'b1;
        #1;
        now_chk("t6_rel", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        cyc("t6_regrant", 4'b1000, 1'b1, 1'b0, 8'h00, 2'd0);
        cyc("t6_data", 4'b1000, 1'b0, 1'b1, 8'h65, 2'd3);
        cyc("t6_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
        req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
